timer_cmd_pulser: RTL and testbench
===================================

// Module: timer_cmd_pulser
// PURPOSE
//  Command-side driver for the pulse-start timer control interface.
//  Accepts timer commands over a valid/ready handshake and emits the matching level pulse on
//  timer_start / timer_stand / timer_reset / timer_restart. Each pulse is followed by a guaranteed
//  low gap, so the timer's rising-edge detectors see exactly one edge per command.
//  Keeps a shadow copy of the timer FSM state for status and software readback.
// PARAMETERS
//  PULSE_WIDTH  2  cycles each control output is held high per command; legal range 1..255
//  GAP_WIDTH    2  cycles all control outputs are held low after a pulse before the next command; legal range 1..255
// PORTS
//  clk            in   1  single clock; all logic on posedge
//  rst_n          in   1  asynchronous, active-low reset
//  cmd_valid      in   1  command present on cmd_code
//  cmd_ready      out  1  block can accept a command; a command is accepted on cmd_valid & cmd_ready
//  cmd_code       in   2  command: 00=START, 01=STAND, 10=RESET, 11=RESTART
//  timer_start    out  1  control level to timer, high during a START pulse
//  timer_stand    out  1  control level to timer, high during a STAND pulse
//  timer_reset    out  1  control level to timer, high during a RESET pulse
//  timer_restart  out  1  control level to timer, high during a RESTART pulse
//  busy           out  1  high in S_PULSE or S_GAP
//  timer_state    out  2  shadow timer state: 00=IDLE, 10=COUNTING, 01=STAND
//  cmd_noop       out  1  one-cycle flag: accepted command causes no shadow-state transition
// BEHAVIOUR
//  Reset values:
//   - timer_start, timer_stand, timer_reset, timer_restart = 0
//   - busy = 0, cmd_noop = 0
//   - cmd_ready = 1
//   - timer_state = 00
//   - internal FSM = S_IDLE, width counter = 0
//  All outputs are registered except cmd_ready, which is (fsm == S_IDLE).
//  Control FSM:
//   - S_IDLE:  cmd_ready = 1. On acceptance in cycle N, latch cmd_code, load counter = PULSE_WIDTH-1, go to S_PULSE.
//   - S_PULSE: exactly one control output is high (one-hot from the latched code). Decrement the counter.
//     When it reaches 0, load GAP_WIDTH-1 and go to S_GAP.
//   - S_GAP:   all control outputs low. Decrement the counter. When it reaches 0, go to S_IDLE.
//  Timing:
//   - Accept in cycle N: output high in cycles N+1 .. N+PULSE_WIDTH.
//   - Output low from N+PULSE_WIDTH+1.
//   - cmd_ready high again in cycle N+PULSE_WIDTH+GAP_WIDTH+1.
//   - Maximum throughput: one command per PULSE_WIDTH+GAP_WIDTH+1 cycles.
//   - A command presented while busy is held by the source. It is not dropped or queued.
//   - cmd_code is sampled only on acceptance; changes during a pulse have no effect.
//  Shadow state (timer_state) and cmd_noop, updated in cycle N+1:
//   - IDLE: START->COUNTING, STAND->STAND, RESTART->COUNTING, RESET->noop
//   - COUNTING: RESET->IDLE, STAND->STAND, START->noop, RESTART->noop
//   - STAND: RESET->IDLE, START->COUNTING, RESTART->COUNTING, STAND->noop
//   - A noop command is still issued as a full pulse. cmd_noop=1 for the single cycle N+1 only.
//  Reset behaviour:
//   - rst_n low at any time, including mid-pulse or mid-gap: every output returns to its reset value
//     immediately and asynchronously.
//   - After release, the first command is accepted normally. No partial pulse is resumed.
//  Width rules: counters are 8 bits; no wrap-around is possible within the legal parameter range.
// TESTING
//  1. Reset, then START at N (PW=2, GAP=2): timer_start high in N+1..N+2; cmd_ready low N+1..N+4, high N+5;
//     timer_state=10 at N+1; cmd_noop stays 0.
//  2. Back-to-back STAND then RESET with cmd_valid held high: second acceptance exactly 5 cycles after the first;
//     at least 2 low cycles between pulses; timer_state goes 01 then 00.
//  3. In COUNTING, issue RESTART: timer_restart pulses for 2 cycles; cmd_noop=1 for one cycle; timer_state stays 10.
//  4. Change cmd_code from START to RESET during S_PULSE: only timer_start toggles; no other output rises.
//  5. Assert rst_n=0 in the first pulse cycle of STAND: all control outputs 0 immediately; timer_state=00;
//     after release, cmd_ready=1 and a START produces a normal 2-cycle pulse.
//  6. PW=1, GAP=1 build: START then STAND accepted 3 cycles apart; each pulse exactly 1 cycle wide.

Source files
------------

// File: rtl/timer_cmd_pulser.sv
// Turns handshaked timer commands into one level pulse per command, each followed by a
// guaranteed low gap. Also keeps a shadow copy of the timer's FSM state.
module timer_cmd_pulser #(
  parameter int PULSE_WIDTH = 2,
  parameter int GAP_WIDTH   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_code,
  output logic       timer_start,
  output logic       timer_stand,
  output logic       timer_reset,
  output logic       timer_restart,
  output logic       busy,
  output logic [1:0] timer_state,
  output logic       cmd_noop
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [1:0] CMD_START   = 2'b00;
  localparam logic [1:0] CMD_STAND   = 2'b01;
  localparam logic [1:0] CMD_RESET   = 2'b10;
  localparam logic [1:0] CMD_RESTART = 2'b11;

  localparam logic [1:0] TS_IDLE     = 2'b00;
  localparam logic [1:0] TS_COUNTING = 2'b10;
  localparam logic [1:0] TS_STAND    = 2'b01;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_WIDTH - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_WIDTH - 1);

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // the source must hold cmd_valid/cmd_code stable until that edge.

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] ctl_q, ctl_next;
  logic [1:0] tstate_next;
  logic       noop_next;
  logic       busy_next;
  logic       accept;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    ctl_next    = ctl_q;
    tstate_next = timer_state;
    noop_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_PULSE;
          cnt_next   = PULSE_LOAD;
          ctl_next   = 4'b0001 << cmd_code;
          // Shadow-state transition table; unlisted pairs leave the state alone.
          case (timer_state)
            TS_IDLE: begin
              case (cmd_code)
                CMD_START, CMD_RESTART: tstate_next = TS_COUNTING;
                CMD_STAND:              tstate_next = TS_STAND;
                default:                noop_next   = 1'b1;
              endcase
            end
            TS_COUNTING: begin
              case (cmd_code)
                CMD_RESET: tstate_next = TS_IDLE;
                CMD_STAND: tstate_next = TS_STAND;
                default:   noop_next   = 1'b1;
              endcase
            end
            TS_STAND: begin
              case (cmd_code)
                CMD_RESET:              tstate_next = TS_IDLE;
                CMD_START, CMD_RESTART: tstate_next = TS_COUNTING;
                default:                noop_next   = 1'b1;
              endcase
            end
            default: tstate_next = TS_IDLE;
          endcase
        end
      end
      S_PULSE: begin
        if (cnt == 8'd0) begin
          state_next = S_GAP;
          cnt_next   = GAP_LOAD;
          ctl_next   = 4'b0000;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      S_GAP: begin
        if (cnt == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
        ctl_next   = 4'b0000;
      end
    endcase
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      ctl_q       <= 4'b0000;
      timer_state <= TS_IDLE;
      cmd_noop    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      ctl_q       <= ctl_next;
      timer_state <= tstate_next;
      cmd_noop    <= noop_next;
      busy        <= busy_next;
    end
  end

  assign timer_start   = ctl_q[0];
  assign timer_stand   = ctl_q[1];
  assign timer_reset   = ctl_q[2];
  assign timer_restart = ctl_q[3];

endmodule

// File: tb/tb_timer_cmd_pulser.sv
// Random and directed commands into timer_cmd_pulser; a scoreboard checks each pulse, the
// busy/ready window and the shadow state against a rule-level reference model.
module tb_timer_cmd_pulser;
  localparam int PW = 2;
  localparam int GW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_code;
  logic       timer_start, timer_stand, timer_reset, timer_restart;
  logic       busy, cmd_noop;
  logic [1:0] timer_state;

  logic       f_valid, f_ready;
  logic [1:0] f_code;
  logic       f_start, f_stand, f_reset, f_restart, f_busy, f_noop;
  logic [1:0] f_state;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         have_acc = 1'b0;
  bit         prev_hold = 1'b0;
  logic [1:0] shadow = 2'b00;
  logic [6:0] exp_q[$];
  logic [3:0] prev_ctl = 4'b0000;

  // ---------------- clock / reset / DUTs
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_cmd_pulser #(.PULSE_WIDTH(PW), .GAP_WIDTH(GW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .timer_start(timer_start), .timer_stand(timer_stand),
    .timer_reset(timer_reset), .timer_restart(timer_restart), .busy(busy),
    .timer_state(timer_state), .cmd_noop(cmd_noop)
  );

  timer_cmd_pulser #(.PULSE_WIDTH(1), .GAP_WIDTH(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_code(f_code), .timer_start(f_start), .timer_stand(f_stand),
    .timer_reset(f_reset), .timer_restart(f_restart), .busy(f_busy),
    .timer_state(f_state), .cmd_noop(f_noop)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: RESET targets IDLE, STAND targets STAND, START/RESTART target COUNTING;
  // a command whose target equals the current state changes nothing. Returns {noop, next}.
  function automatic logic [2:0] model_step(input logic [1:0] st, input logic [1:0] code);
    logic [1:0] target;
    case (code)
      2'b10:   target = 2'b00;
      2'b01:   target = 2'b01;
      default: target = 2'b10;
    endcase
    return {(st == target), target};
  endfunction

  // ---------------- driver (called at a falling edge)
  task automatic send(input logic [1:0] code, input bit hold, input bit rst_mid);
    logic [2:0] m;
    logic [3:0] oh;
    bit         got;
    got = 1'b0;
    cmd_valid = 1'b1;
    cmd_code  = code;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("accept_timeout", 8'd0, 8'd1);
      cmd_valid = 1'b0;
      prev_hold = 1'b0;
      return;
    end
    if (prev_hold) check("b2b_interval", 8'(cyc - acc_cyc), 8'(PW + GW + 1));
    m  = model_step(shadow, code);
    oh = 4'b0001 << code;
    exp_q.push_back({m[2], m[1:0], oh});
    shadow   = m[1:0];
    acc_cyc  = cyc;
    have_acc = 1'b1;
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_code  = 2'($urandom);
    end
    prev_hold = hold;
    if (rst_mid) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_ctl", 8'({timer_restart, timer_reset, timer_stand, timer_start}), 8'd0);
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_ready", 8'(cmd_ready), 8'd1);
      check("rst_state", 8'(timer_state), 8'd0);
      check("rst_noop", 8'(cmd_noop), 8'd0);
      shadow    = 2'b00;
      have_acc  = 1'b0;
      prev_hold = 1'b0;
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  // ---------------- monitor / scoreboard
  always @(negedge clk) begin
    logic [3:0] ctl;
    logic [6:0] e;
    int         d;
    bit         in_pulse, in_busy;
    if (!rst_n) begin
      exp_q.delete();
      prev_ctl = 4'b0000;
    end else begin
      ctl      = {timer_restart, timer_reset, timer_stand, timer_start};
      d        = cyc - acc_cyc;
      in_pulse = have_acc && d >= 1 && d <= PW;
      in_busy  = have_acc && d >= 1 && d <= PW + GW;
      check("pulse_level", 8'(ctl != 4'b0000), 8'(in_pulse));
      check("busy", 8'(busy), 8'(in_busy));
      check("cmd_ready", 8'(cmd_ready), 8'(!in_busy));
      if (ctl != 4'b0000 && prev_ctl == 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 8'(ctl), 8'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_code", 8'(ctl), 8'(e[3:0]));
          check("shadow_state", 8'(timer_state), 8'(e[5:4]));
          check("noop_flag", 8'(cmd_noop), 8'(e[6]));
        end
      end else begin
        check("noop_idle", 8'(cmd_noop), 8'd0);
        if (ctl != 4'b0000) check("pulse_stable", 8'(ctl), 8'(prev_ctl));
      end
      prev_ctl = ctl;
    end
  end

  // ---------------- stimulus
  initial begin
    int acc1, starts;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 2'b00;
    f_valid   = 1'b0;
    f_code    = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_ctl", 8'({timer_restart, timer_reset, timer_stand, timer_start}), 8'd0);
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_noop", 8'(cmd_noop), 8'd0);
    check("reset_ready", 8'(cmd_ready), 8'd1);
    check("reset_state", 8'(timer_state), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(2'b00, 1'b0, 1'b0);            // START from IDLE
    repeat (4) @(negedge clk);
    send(2'b01, 1'b1, 1'b0);            // STAND, held into RESET
    send(2'b10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    send(2'b00, 1'b0, 1'b0);            // START, then RESTART as a noop
    send(2'b11, 1'b0, 1'b0);
    send(2'b01, 1'b0, 1'b1);            // reset asserted in first STAND pulse cycle
    send(2'b00, 1'b0, 1'b0);
    send(2'b10, 1'b0, 1'b0);            // RESET while IDLE-bound -> back to IDLE
    send(2'b10, 1'b0, 1'b0);            // RESET in IDLE is a noop

    for (int n = 0; n < 60; n++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      send(2'($urandom_range(0, 3)), h, 1'b0);
      if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    cmd_valid = 1'b0;
    prev_hold = 1'b0;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || !cmd_ready); i++) @(negedge clk);
    check("drain_queue", 8'(exp_q.size()), 8'd0);

    // PW=1/GW=1 instance: START then STAND with valid held.
    f_valid = 1'b1;
    f_code  = 2'b00;
    acc1    = -1;
    for (int i = 0; i < 20; i++) begin
      if (f_ready) begin
        acc1 = cyc;
        break;
      end
      @(negedge clk);
    end
    check("fast_accept1", 8'(acc1 >= 0), 8'd1);
    @(negedge clk);
    f_code = 2'b01;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      if (f_ready) break;
      starts += int'(f_start);
      @(negedge clk);
    end
    check("fast_interval", 8'(cyc - acc1), 8'd3);
    check("fast_start_width", 8'(starts), 8'd1);
    @(negedge clk);
    f_valid = 1'b0;
    check("fast_stand_on", 8'(f_stand), 8'd1);
    check("fast_state", 8'(f_state), 8'b01);
    @(negedge clk);
    check("fast_stand_off", 8'(f_stand), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
